// File: rtl/rom_arb_pkg.sv
// rom_arb_pkg -- shared definitions for the monitor-ROM arbiter.
//   ROM_AW    : ROM byte-address width (8K ROM)
//   DW        : ROM data width
//   WCW       : wait-state counter width
//   state_t   : arbiter FSM state type and its three state constants
//   pick_port : round-robin winner selection between the two request ports
package rom_arb_pkg;

   localparam int ROM_AW = 13;
   localparam int DW     = 8;
   localparam int WCW    = 4;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_ACCESS = 2'd1;
   localparam state_t ST_DONE   = 2'd2;

   // A lone requester always wins; on a tie the port that was not granted
   // last time wins. Result is meaningless when nobody is requesting.
   function automatic logic pick_port(input logic req0, input logic req1,
                                      input logic last_grant);
      if (req0 && req1) begin
         return !last_grant;
      end
      return req1;
   endfunction

endpackage

// File: rtl/rom_arbiter_if.sv
// rom_arbiter_if -- bundle of the two read ports and the ROM bus.
//   req0/addr0/ack0/rdata0 : port 0 (CPU fetch) request/ack handshake
//   req1/addr1/ack1/rdata1 : port 1 (debug/loader) request/ack handshake
//   rom_sel/rom_a/rom_dout : chip select, address and data of the async ROM
// Modports:
//   slave  : the arbiter side
//   master : the environment (requesters plus the ROM data source)
interface rom_arbiter_if;
   import rom_arb_pkg::*;

   logic              req0;
   logic [ROM_AW-1:0] addr0;
   logic              ack0;
   logic [DW-1:0]     rdata0;
   logic              req1;
   logic [ROM_AW-1:0] addr1;
   logic              ack1;
   logic [DW-1:0]     rdata1;
   logic              rom_sel;
   logic [ROM_AW-1:0] rom_a;
   logic [DW-1:0]     rom_dout;

   modport slave (
      input  req0, addr0, req1, addr1, rom_dout,
      output ack0, rdata0, ack1, rdata1, rom_sel, rom_a
   );

   modport master (
      output req0, addr0, req1, addr1, rom_dout,
      input  ack0, rdata0, ack1, rdata1, rom_sel, rom_a
   );

endinterface

// File: rtl/rom_arb_wait_ctr.sv
// rom_arb_wait_ctr -- loadable down-counter timing the ROM access window.
//   clk      : clock
//   rst_n    : asynchronous active-low reset (count -> 0)
//   load     : load load_val (has priority over dec)
//   load_val : value to load
//   dec      : decrement by one; saturates at zero
//   zero     : count is zero
module rom_arb_wait_ctr
   import rom_arb_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   input  logic           load,
   input  logic [WCW-1:0] load_val,
   input  logic           dec,
   output logic           zero
);

   logic [WCW-1:0] count_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_val;
      end else if (dec && (count_reg != '0)) begin
         count_reg <= count_reg - WCW'(1);
      end
   end

   assign zero = (count_reg == '0);

endmodule

// File: rtl/rom_arbiter.sv
// rom_arbiter -- two-port round-robin read arbiter for the 8K async monitor ROM.
//   WAIT_STATES : extra cycles rom_a is held before rom_dout is sampled (0..15)
//   clk         : clock, all state changes on the rising edge
//   rst_n       : asynchronous active-low reset
//   bus         : rom_arbiter_if.slave -- both request ports and the ROM bus
// One access = IDLE (grant) -> ACCESS (WAIT_STATES+1 cycles) -> DONE (ack).
module rom_arbiter
   import rom_arb_pkg::*;
#(
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   rom_arbiter_if.slave bus
);

   localparam logic [WCW-1:0] WAIT_LOAD = WCW'(WAIT_STATES);

   state_t            state_reg;
   logic              last_grant_reg;
   logic              winner_reg;
   logic [ROM_AW-1:0] rom_a_reg;
   logic              rom_sel_reg;

   logic              grant;
   logic              grant_port;
   logic              ctr_zero;
   logic              ctr_dec;
   logic              finish;
   logic [ROM_AW-1:0] addr_vec [2];

   assign addr_vec[0] = bus.addr0;
   assign addr_vec[1] = bus.addr1;

   assign grant      = (state_reg == ST_IDLE) && (bus.req0 || bus.req1);
   assign grant_port = pick_port(bus.req0, bus.req1, last_grant_reg);
   // Last ACCESS cycle: the ROM has had WAIT_STATES extra cycles to settle.
   assign finish     = (state_reg == ST_ACCESS) && ctr_zero;
   assign ctr_dec    = (state_reg == ST_ACCESS) && !ctr_zero;

   rom_arb_wait_ctr u_wait_ctr (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (grant),
      .load_val (WAIT_LOAD),
      .dec      (ctr_dec),
      .zero     (ctr_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= ST_IDLE;
         last_grant_reg <= 1'b1;   // port 0 wins the first tie
         winner_reg     <= 1'b0;
         rom_a_reg      <= '0;
         rom_sel_reg    <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (grant) begin
                  state_reg      <= ST_ACCESS;
                  winner_reg     <= grant_port;
                  last_grant_reg <= grant_port;
                  rom_a_reg      <= addr_vec[grant_port];
                  rom_sel_reg    <= 1'b1;
               end
            end
            ST_ACCESS: begin
               if (ctr_zero) begin
                  state_reg   <= ST_DONE;
                  rom_sel_reg <= 1'b0;   // rom_a keeps its value through DONE
               end
            end
            ST_DONE: begin
               state_reg <= ST_IDLE;
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   // Per-port result registers: only the winner's data and ack move, so the
   // other port's rdata is untouched and both acks can never coincide.
   for (genvar gi = 0; gi < 2; gi++) begin : g_port
      logic          hit;
      logic          ack_reg;
      logic [DW-1:0] rdata_reg;

      assign hit = finish && (winner_reg == 1'(gi));

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            ack_reg   <= 1'b0;
            rdata_reg <= '0;
         end else begin
            ack_reg <= hit;
            if (hit) begin
               rdata_reg <= bus.rom_dout;
            end
         end
      end
   end

   assign bus.ack0    = g_port[0].ack_reg;
   assign bus.rdata0  = g_port[0].rdata_reg;
   assign bus.ack1    = g_port[1].ack_reg;
   assign bus.rdata1  = g_port[1].rdata_reg;
   assign bus.rom_sel = rom_sel_reg;
   assign bus.rom_a   = rom_a_reg;

endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter -- bench for rom_arbiter. Three instances with
// WAIT_STATES = 0, 1 and 3 each see their own copy of a random ROM image.
// Directed scenarios cover reset, single reads, ties, alternation, reset
// mid-access and mid-access request drop; a random phase checks every
// output every cycle against a transaction-level timing model.
module tb_rom_arbiter;

   localparam int NI = 3;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic [NI-1:0] req0_v = '0;
   logic [NI-1:0] req1_v = '0;
   logic [12:0]   addr0_v [NI];
   logic [12:0]   addr1_v [NI];
   logic [NI-1:0] ack0_w;
   logic [NI-1:0] ack1_w;
   logic [NI-1:0] sel_w;
   logic [7:0]    rdata0_w [NI];
   logic [7:0]    rdata1_w [NI];
   logic [12:0]   rom_a_w [NI];
   logic [7:0]    mem [8192];

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   function automatic int ws_of(input int d);
      return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
   endfunction

   for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      rom_arbiter_if bus ();

      assign bus.req0     = req0_v[gi];
      assign bus.addr0    = addr0_v[gi];
      assign bus.req1     = req1_v[gi];
      assign bus.addr1    = addr1_v[gi];
      assign bus.rom_dout = bus.rom_sel ? mem[bus.rom_a] : 8'hA5;

      assign ack0_w[gi]   = bus.ack0;
      assign ack1_w[gi]   = bus.ack1;
      assign sel_w[gi]    = bus.rom_sel;
      assign rdata0_w[gi] = bus.rdata0;
      assign rdata1_w[gi] = bus.rdata1;
      assign rom_a_w[gi]  = bus.rom_a;

      rom_arbiter #(
         .WAIT_STATES ((gi == 0) ? 0 : ((gi == 1) ? 1 : 3))
      ) u_dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (bus)
      );
   end

   function automatic logic [12:0] rnd_addr();
      case ($urandom_range(3))
         0:       return 13'h0000;
         1:       return 13'h1FFF;
         default: return 13'($urandom);
      endcase
   endfunction

   task automatic clear_reqs();
      for (int d = 0; d < NI; d++) begin
         req0_v[d]  = 1'b0;
         req1_v[d]  = 1'b0;
         addr0_v[d] = '0;
         addr1_v[d] = '0;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_reqs();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Advance negedge by negedge until an ack shows up on instance d or max
   // cycles pass. k = cycle index of the ack (-1 if none). Drops the acked
   // port's request when drop is set.
   task automatic watch(input int d, input int max, input bit drop,
                        output int k, output int port, output int sel_cnt,
                        output bit both);
      k = -1; port = -1; sel_cnt = 0; both = 1'b0;
      for (int i = 1; i <= max; i++) begin
         @(negedge clk);
         if (sel_w[d]) sel_cnt++;
         if (ack0_w[d] && ack1_w[d]) both = 1'b1;
         if (ack0_w[d] || ack1_w[d]) begin
            k    = i;
            port = ack0_w[d] ? 0 : 1;
            if (drop) begin
               if (port == 0) req0_v[d] = 1'b0;
               else           req1_v[d] = 1'b0;
            end
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      clear_reqs();
      @(negedge clk);
      for (int d = 0; d < NI; d++) begin
         vectors++;
         if ({ack0_w[d], ack1_w[d], sel_w[d]} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_ctrl[%0d]: got ack0/ack1/sel=%b required 000", d,
                     {ack0_w[d], ack1_w[d], sel_w[d]});
         end
         vectors++;
         if (rom_a_w[d] !== 13'h0000) begin
            miscompares++;
            $display("FAIL reset_rom_a[%0d]: got %h required 0000", d, rom_a_w[d]);
         end
         vectors++;
         if ({rdata0_w[d], rdata1_w[d]} !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_rdata[%0d]: got %h/%h required 00/00", d,
                     rdata0_w[d], rdata1_w[d]);
         end
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      for (int d = 0; d < NI; d++) begin
         vectors++;
         if ({ack0_w[d], ack1_w[d], sel_w[d]} !== 3'b000) begin
            miscompares++;
            $display("FAIL idle_after_reset[%0d]: got ack0/ack1/sel=%b required 000", d,
                     {ack0_w[d], ack1_w[d], sel_w[d]});
         end
      end
      $display("txn reset: all instances checked");
   endtask

   // Lone request on one port: latency, select window, data and no repeat.
   task automatic test_single(input int d, input int port, input logic [12:0] addr);
      int k, p, selc, kr, pr, selr;
      bit both, bothr;
      logic [7:0] rd;
      int ws;
      ws = ws_of(d);
      repeat (2) @(negedge clk);
      if (port == 0) begin addr0_v[d] = addr; req0_v[d] = 1'b1; end
      else           begin addr1_v[d] = addr; req1_v[d] = 1'b1; end
      watch(d, 20, 1'b1, k, p, selc, both);
      rd = (port == 0) ? rdata0_w[d] : rdata1_w[d];
      $display("txn single ws=%0d port=%0d addr=%h data=%h lat=%0d", ws, p, addr, rd, k);
      vectors++;
      if (k !== ws + 2) begin
         miscompares++;
         $display("FAIL single_latency ws=%0d: got %0d required %0d", ws, k, ws + 2);
      end
      vectors++;
      if (p !== port) begin
         miscompares++;
         $display("FAIL single_port ws=%0d: got %0d required %0d", ws, p, port);
      end
      vectors++;
      if (selc !== ws + 1) begin
         miscompares++;
         $display("FAIL single_sel_cycles ws=%0d: got %0d required %0d", ws, selc, ws + 1);
      end
      vectors++;
      if (rd !== mem[addr]) begin
         miscompares++;
         $display("FAIL single_rdata ws=%0d: got %h required %h", ws, rd, mem[addr]);
      end
      vectors++;
      if (rom_a_w[d] !== addr) begin
         miscompares++;
         $display("FAIL single_rom_a ws=%0d: got %h required %h", ws, rom_a_w[d], addr);
      end
      watch(d, 8, 1'b1, kr, pr, selr, bothr);
      vectors++;
      if (kr !== -1 || selr !== 0) begin
         miscompares++;
         $display("FAIL single_no_repeat ws=%0d: got ack at %0d sel cycles %0d required none",
                  ws, kr, selr);
      end
   endtask

   task automatic test_tie();
      int k, p, selc;
      bit both;
      do_reset();
      addr0_v[1] = 13'h0010; addr1_v[1] = 13'h1FFF;
      req0_v[1] = 1'b1;      req1_v[1] = 1'b1;
      watch(1, 20, 1'b1, k, p, selc, both);
      $display("txn tie first port=%0d data=%h lat=%0d", p, rdata0_w[1], k);
      vectors++;
      if (p !== 0 || k !== 3) begin
         miscompares++;
         $display("FAIL tie_first: got port %0d at %0d required port 0 at 3", p, k);
      end
      vectors++;
      if (rdata0_w[1] !== mem[13'h0010]) begin
         miscompares++;
         $display("FAIL tie_rdata0: got %h required %h", rdata0_w[1], mem[13'h0010]);
      end
      watch(1, 20, 1'b1, k, p, selc, both);
      $display("txn tie second port=%0d data=%h gap=%0d", p, rdata1_w[1], k);
      vectors++;
      if (p !== 1 || k !== 4) begin
         miscompares++;
         $display("FAIL tie_second: got port %0d after %0d required port 1 after 4", p, k);
      end
      vectors++;
      if (rdata1_w[1] !== mem[13'h1FFF] || rdata0_w[1] !== mem[13'h0010]) begin
         miscompares++;
         $display("FAIL tie_rdata: got %h/%h required %h/%h", rdata0_w[1], rdata1_w[1],
                  mem[13'h0010], mem[13'h1FFF]);
      end
   endtask

   task automatic test_alternate();
      int k, p, selc;
      bit both, any_both;
      logic [12:0] a;
      logic [7:0] rd;
      any_both = 1'b0;
      repeat (2) @(negedge clk);
      addr0_v[1] = rnd_addr(); addr1_v[1] = rnd_addr();
      req0_v[1] = 1'b1;        req1_v[1] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         watch(1, 20, 1'b0, k, p, selc, both);
         any_both |= both;
         a  = (p == 1) ? addr1_v[1] : addr0_v[1];
         rd = (p == 1) ? rdata1_w[1] : rdata0_w[1];
         $display("txn alternate #%0d port=%0d addr=%h data=%h gap=%0d", i, p, a, rd, k);
         vectors++;
         if (p !== (i % 2) || k !== ((i == 0) ? 3 : 4)) begin
            miscompares++;
            $display("FAIL alt_grant #%0d: got port %0d after %0d required port %0d after %0d",
                     i, p, k, i % 2, (i == 0) ? 3 : 4);
         end
         vectors++;
         if (rd !== mem[a]) begin
            miscompares++;
            $display("FAIL alt_rdata #%0d: got %h required %h", i, rd, mem[a]);
         end
         if (p == 0) addr0_v[1] = rnd_addr();
         else if (p == 1) addr1_v[1] = rnd_addr();
      end
      req0_v[1] = 1'b0; req1_v[1] = 1'b0;
      vectors++;
      if (any_both) begin
         miscompares++;
         $display("FAIL alt_both_acks: got simultaneous acks required never");
      end
   endtask

   task automatic test_reset_mid();
      int k, p, selc;
      bit both;
      logic [12:0] a;
      repeat (2) @(negedge clk);
      a = rnd_addr();
      addr1_v[1] = a; req1_v[1] = 1'b1;
      @(negedge clk);
      vectors++;
      if (sel_w[1] !== 1'b1) begin
         miscompares++;
         $display("FAIL rstmid_started: got rom_sel %b required 1", sel_w[1]);
      end
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if ({ack0_w[1], ack1_w[1], sel_w[1], rom_a_w[1], rdata0_w[1], rdata1_w[1]} !== 32'h0) begin
         miscompares++;
         $display("FAIL rstmid_outputs: got ack %b%b sel %b rom_a %h rdata %h/%h required all zero",
                  ack0_w[1], ack1_w[1], sel_w[1], rom_a_w[1], rdata0_w[1], rdata1_w[1]);
      end
      req1_v[1] = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      watch(1, 6, 1'b1, k, p, selc, both);
      vectors++;
      if (k !== -1) begin
         miscompares++;
         $display("FAIL rstmid_no_ack: got ack on port %0d required none", p);
      end
      a = rnd_addr();
      addr1_v[1] = a; req1_v[1] = 1'b1;
      watch(1, 20, 1'b1, k, p, selc, both);
      $display("txn after-reset port=%0d addr=%h data=%h lat=%0d", p, a, rdata1_w[1], k);
      vectors++;
      if (p !== 1 || k !== 3 || rdata1_w[1] !== mem[a]) begin
         miscompares++;
         $display("FAIL rstmid_resume: got port %0d lat %0d data %h required port 1 lat 3 data %h",
                  p, k, rdata1_w[1], mem[a]);
      end
   endtask

   task automatic test_drop_mid();
      int k, p, selc;
      bit both, early;
      logic [12:0] a;
      early = 1'b0;
      repeat (2) @(negedge clk);
      a = rnd_addr();
      addr0_v[2] = a; req0_v[2] = 1'b1;
      repeat (2) begin
         @(negedge clk);
         early |= ack0_w[2] | ack1_w[2];
      end
      req0_v[2] = 1'b0;
      watch(2, 10, 1'b1, k, p, selc, both);
      $display("txn drop-mid port=%0d addr=%h data=%h lat=%0d", p, a, rdata0_w[2], k + 2);
      vectors++;
      if (early || p !== 0 || k + 2 !== 5) begin
         miscompares++;
         $display("FAIL drop_ack: got port %0d lat %0d early %b required port 0 lat 5",
                  p, k + 2, early);
      end
      vectors++;
      if (rdata0_w[2] !== mem[a]) begin
         miscompares++;
         $display("FAIL drop_rdata: got %h required %h", rdata0_w[2], mem[a]);
      end
      watch(2, 10, 1'b1, k, p, selc, both);
      vectors++;
      if (k !== -1 || selc !== 0) begin
         miscompares++;
         $display("FAIL drop_no_second: got ack at %0d sel cycles %0d required none", k, selc);
      end
   endtask

   // Random requesters against a transaction-level model: a grant happens on
   // the first edge where the arbiter is free and someone requests; that
   // access selects the ROM for ws+1 cycles, acks ws+1 edges after the grant,
   // and the arbiter can grant again ws+3 edges after the grant.
   task automatic test_random(input int d, input int ncyc);
      int ws, e, free_e, g_e, g_p, last;
      bit busy, r0, r1, exp_ack0, exp_ack1, exp_sel;
      bit outst [2];
      logic [12:0] g_a, exp_a;
      logic [7:0] exp_rd [2];
      ws = ws_of(d);
      do_reset();
      e = 0; free_e = 0; busy = 1'b0; last = 1; g_e = 0; g_p = 0; g_a = '0;
      exp_a = '0; exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
      outst[0] = 1'b0; outst[1] = 1'b0;
      for (int c = 0; c < ncyc; c++) begin
         r0 = req0_v[d];
         r1 = req1_v[d];
         @(negedge clk);
         e++;
         if (busy && e == g_e + ws + 2) busy = 1'b0;
         if (!busy && e >= free_e && (r0 || r1)) begin
            g_p    = (r0 && r1) ? 1 - last : (r0 ? 0 : 1);
            last   = g_p;
            g_e    = e;
            busy   = 1'b1;
            g_a    = (g_p == 1) ? addr1_v[d] : addr0_v[d];
            exp_a  = g_a;
            free_e = e + ws + 3;
         end
         exp_sel  = busy && (e <= g_e + ws);
         exp_ack0 = busy && (e == g_e + ws + 1) && (g_p == 0);
         exp_ack1 = busy && (e == g_e + ws + 1) && (g_p == 1);
         if (busy && e == g_e + ws + 1) begin
            exp_rd[g_p] = mem[g_a];
            $display("txn random ws=%0d port=%0d addr=%h data=%h edge=%0d", ws, g_p, g_a,
                     mem[g_a], e);
         end
         vectors += 6;
         if (ack0_w[d] !== exp_ack0) begin
            miscompares++;
            $display("FAIL rnd_ack0 ws=%0d edge %0d: got %b required %b", ws, e, ack0_w[d], exp_ack0);
         end
         if (ack1_w[d] !== exp_ack1) begin
            miscompares++;
            $display("FAIL rnd_ack1 ws=%0d edge %0d: got %b required %b", ws, e, ack1_w[d], exp_ack1);
         end
         if (sel_w[d] !== exp_sel) begin
            miscompares++;
            $display("FAIL rnd_sel ws=%0d edge %0d: got %b required %b", ws, e, sel_w[d], exp_sel);
         end
         if (rom_a_w[d] !== exp_a) begin
            miscompares++;
            $display("FAIL rnd_rom_a ws=%0d edge %0d: got %h required %h", ws, e, rom_a_w[d], exp_a);
         end
         if (rdata0_w[d] !== exp_rd[0]) begin
            miscompares++;
            $display("FAIL rnd_rdata0 ws=%0d edge %0d: got %h required %h", ws, e, rdata0_w[d], exp_rd[0]);
         end
         if (rdata1_w[d] !== exp_rd[1]) begin
            miscompares++;
            $display("FAIL rnd_rdata1 ws=%0d edge %0d: got %h required %h", ws, e, rdata1_w[d], exp_rd[1]);
         end
         // requester behaviour: hold until ack, may drop once granted
         for (int p = 0; p < 2; p++) begin
            if ((p == 0) ? ack0_w[d] : ack1_w[d]) begin
               outst[p] = 1'b0;
               if (p == 0) req0_v[d] = 1'b0; else req1_v[d] = 1'b0;
            end else if (outst[p]) begin
               if (busy && g_p == p && $urandom_range(3) == 0) begin
                  if (p == 0) req0_v[d] = 1'b0; else req1_v[d] = 1'b0;
               end
            end else if ($urandom_range(2) == 0) begin
               outst[p] = 1'b1;
               if (p == 0) begin addr0_v[d] = rnd_addr(); req0_v[d] = 1'b1; end
               else        begin addr1_v[d] = rnd_addr(); req1_v[d] = 1'b1; end
            end
         end
      end
      clear_reqs();
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 8192; i++) begin
         mem[i] = 8'($urandom);
      end
      mem[0] = 8'h7E;
      clear_reqs();
      test_reset();
      test_single(1, 0, 13'h0000);
      test_tie();
      test_alternate();
      test_single(0, 1, 13'h0100);
      test_reset_mid();
      test_drop_mid();
      for (int d = 0; d < NI; d++) begin
         test_random(d, 250);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
